seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder; successor to the combinational 1-bit full adder and 4-bit ripple adder.
- Adds two WIDTH-bit operands plus carry-in, processing CHUNK bits per clock through an internal CHUNK-bit ripple stage.
- Trades latency for area.
- Uses a start/busy/done handshake so a controller can issue back-to-back additions.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be ≥1.
- CHUNK, 4, bits added per cycle; must divide WIDTH exactly, 1 ≤ CHUNK ≤ WIDTH.
- NCHUNK (localparam) = WIDTH/CHUNK, cycles per addition.

Ports:
- clk  input  1  Single clock; all state updates on rising edge.
- rst_n  input  1  Synchronous, active-low reset, sampled on rising edge of clk.
- start  input  1  Request; sampled only when busy=0.
- A  input  WIDTH  Operand A; captured on the accepted-start edge.
- B  input  WIDTH  Operand B; captured on the accepted-start edge.
- C_in  input  1  Carry-in; captured on the accepted-start edge.
- busy  output  1  High while an addition is in progress.
- done  output  1  One-cycle pulse when a new result is valid.
- S  output  WIDTH  Sum of the last completed addition.
- C_out  output  1  Unsigned carry-out of the last completed addition.
- overflow  output  1  Two's-complement overflow of the last completed addition.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; busy=0, done=0, S=0, C_out=0, overflow=0.
  - Chunk index, carry and operand registers cleared.
  - Reset has priority over every other event, including mid-CALC: the partial result is discarded, no done pulse, outputs read 0.
- FSM states: IDLE, CALC.
- IDLE:
  - start=1 at edge → latch A, B, C_in; idx=0; carry=C_in; busy=1; state→CALC.
  - start=0 → remain in IDLE.
- CALC, each edge:
  - {c, p} = A[idx*CHUNK +: CHUNK] + B[idx*CHUNK +: CHUNK] + carry, computed in CHUNK+1 bits.
  - Write p into the internal accumulator chunk idx; carry=c; idx=idx+1.
- Last CALC edge (idx=NCHUNK-1):
  - S ← full accumulator including the final chunk; C_out ← final carry.
  - overflow ← (A[WIDTH-1]==B[WIDTH-1]) && (S_new[WIDTH-1]!=A[WIDTH-1]).
  - done=1, busy=0, state→IDLE.
- Latency: done is high in the cycle after the NCHUNK-th edge following the start edge. With CHUNK=WIDTH, done follows the edge after start.
- done is high for exactly one cycle; otherwise 0.
- S, C_out and overflow update only on the done edge and hold until the next completion. Intermediate partial sums are never visible on S.
- start while busy=1 is ignored; no queuing, operands not re-latched.
- start=1 in the cycle done=1 (state IDLE) is accepted, giving back-to-back throughput of one result per NCHUNK+1 cycles.
- Arithmetic is modulo 2^WIDTH on S, with the carry beyond bit WIDTH-1 on C_out. Result is bit-identical to A+B+C_in for all inputs.
- Input changes on A, B or C_in after the start edge have no effect on the current addition.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, start=0 → busy=0, done=0, S=0x0000, C_out=0, overflow=0.
- Carry ripple across all chunks (WIDTH=16, CHUNK=4): A=0xFFFF, B=0x0001, C_in=0, start 1 cycle → busy high 4 cycles; done pulses in the 5th cycle; S=0x0000, C_out=1, overflow=0.
- Signed overflow: A=0x7FFF, B=0x0001, C_in=0 → S=0x8000, C_out=0, overflow=1. Then A=0x8000, B=0x8000, C_in=1 → S=0x0001, C_out=1, overflow=1.
- Busy protection and back-to-back:
  - Assert start with A=0x1234, B=0x1111; pulse start with A=0xFFFF during busy → result S=0x2345, single done.
  - Assert start in the done cycle with A=0x0003, B=0x0004, C_in=1 → next done gives S=0x0008.
- Reset mid-operation: start A=0x00FF, B=0x0001; drive rst_n=0 on the 2nd CALC cycle → no done pulse, S=0, busy=0. A new start after release gives the correct sum.
- Parameter sweep: WIDTH=4 with CHUNK=1, 2, 4; all 512 combinations of A, B, C_in → {C_out,S} equals A+B+C_in. Latency is 4, 2 and 1 cycles respectively.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder
//   Multi-cycle WIDTH-bit adder. Operands are latched on an accepted start and
//   summed CHUNK bits per clock through a CHUNK-bit ripple stage. S, C_out and
//   overflow hold the last completed result and change only on the done edge.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // Keep the chunk index at least one bit wide so CHUNK == WIDTH still elaborates.
  localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic [CHUNK-1:0]  chunk_a;
  logic [CHUNK-1:0]  chunk_b;
  logic [CHUNK:0]    chunk_sum;
  logic [WIDTH-1:0]  acc_upd;

  // Select the operand chunks addressed by the current chunk index.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (idx_q == IDXW'(k)) begin
        chunk_a = a_q[k*CHUNK +: CHUNK];
        chunk_b = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  // CHUNK-bit ripple stage: partial sum plus carry into the next chunk.
  always_comb begin
    chunk_sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
  end

  // Accumulator with the current chunk's partial sum merged in.
  always_comb begin
    acc_upd = acc_q;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (idx_q == IDXW'(k)) begin
        acc_upd[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
      end
    end
  end

  // Next-state and datapath control; results publish only on completion.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = C_in;
          idx_d   = '0;
          acc_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = acc_upd;
        carry_d = chunk_sum[CHUNK];
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          s_d     = acc_upd;
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (acc_upd[WIDTH-1] != a_q[WIDTH-1]);
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == CALC);
  assign done     = done_q;
  assign S        = s_q;
  assign C_out    = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: 16/4 default instance plus 4-bit
// instances with CHUNK = 1, 2, 4 swept over every operand combination.
module tb_seq_chunk_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] A, B;
  logic        C_in;
  logic        busy, done;
  logic [15:0] S;
  logic        C_out, overflow;

  logic [2:0]  start4;
  logic [3:0]  a4, b4;
  logic        cin4;
  logic [2:0]  busy4, done4, cout4, ovf4;
  logic [3:0]  s4 [3];

  int checks = 0;
  int errors = 0;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .C_in(C_in),
    .busy(busy), .done(done), .S(S), .C_out(C_out), .overflow(overflow)
  );

  seq_chunk_adder #(.WIDTH(4), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst_n(rst_n), .start(start4[0]), .A(a4), .B(b4), .C_in(cin4),
    .busy(busy4[0]), .done(done4[0]), .S(s4[0]), .C_out(cout4[0]), .overflow(ovf4[0])
  );

  seq_chunk_adder #(.WIDTH(4), .CHUNK(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .start(start4[1]), .A(a4), .B(b4), .C_in(cin4),
    .busy(busy4[1]), .done(done4[1]), .S(s4[1]), .C_out(cout4[1]), .overflow(ovf4[1])
  );

  seq_chunk_adder #(.WIDTH(4), .CHUNK(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .start(start4[2]), .A(a4), .B(b4), .C_in(cin4),
    .busy(busy4[2]), .done(done4[2]), .S(s4[2]), .C_out(cout4[2]), .overflow(ovf4[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for done on the 16-bit instance; returns edges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  // Issue one 16-bit addition and check latency and result; returns in the done cycle.
  task automatic add16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [15:0] exp_s, input logic exp_c,
                       input logic exp_o);
    int n;
    start = 1'b1; A = a; B = b; C_in = cin;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    wait_done(n);
    check({tag, "_lat"}, n, 4);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_S"}, S, exp_s);
    check({tag, "_Cout"}, C_out, exp_c);
    check({tag, "_ovf"}, overflow, exp_o);
  endtask

  initial begin
    int n;
    logic [4:0] exp5;
    logic       exp_ovf;

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; C_in = 1'b0;
    start4 = '0; a4 = '0; b4 = '0; cin4 = 1'b0;

    // Reset then idle
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_S", S, 16'h0000);
    check("rst_Cout", C_out, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    // Carry ripple across all chunks
    add16("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    check("ripple_done_pulse", done, 0);
    check("ripple_S_hold", S, 16'h0000);

    // Signed overflow cases
    add16("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    tick();
    add16("ovf_neg", 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
    tick();

    // Busy protection: a second start mid-operation is ignored
    start = 1'b1; A = 16'h1234; B = 16'h1111; C_in = 1'b0;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; A = 16'hFFFF;
    tick();
    start = 1'b0;
    check("busy_S_hidden", S, 16'h0001);
    wait_done(n);
    check("busy_lat", n, 2);
    check("busy_S", S, 16'h2345);
    check("busy_Cout", C_out, 0);
    check("busy_ovf", overflow, 0);

    // Back-to-back: start accepted in the done cycle
    start = 1'b1; A = 16'h0003; B = 16'h0004; C_in = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_single_done", done, 0);
    check("b2b_busy", busy, 1);
    check("b2b_S_hold", S, 16'h2345);
    wait_done(n);
    check("b2b_lat", n, 4);
    check("b2b_S", S, 16'h0008);
    check("b2b_Cout", C_out, 0);
    check("b2b_ovf", overflow, 0);
    tick();

    // Reset in the 2nd CALC cycle discards the addition
    start = 1'b1; A = 16'h00FF; B = 16'h0001; C_in = 1'b0;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_S", S, 16'h0000);
    check("midrst_Cout", C_out, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_no_done", done, 0);
    end
    add16("after_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    tick();

    // Exhaustive 4-bit sweep for CHUNK = 1, 2, 4 (latency 4, 2, 1)
    for (int k = 0; k < 3; k++) begin
      for (int v = 0; v < 512; v++) begin
        a4   = 4'(v);
        b4   = 4'(v >> 4);
        cin4 = v[8];
        exp5 = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
        exp_ovf = (a4[3] == b4[3]) && (exp5[3] != a4[3]);
        start4[k] = 1'b1;
        tick();
        start4[k] = 1'b0;
        check("sweep_busy", busy4[k], 1);
        n = 0;
        while (done4[k] !== 1'b1 && n < 20) begin
          tick();
          n++;
        end
        check("sweep_lat", n, (k == 0) ? 4 : (k == 1) ? 2 : 1);
        check("sweep_sum", {cout4[k], s4[k]}, exp5);
        check("sweep_ovf", ovf4[k], exp_ovf);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
